// File: rtl/booth_pkg.sv
// Shared types and Booth op-code helpers for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] booth_op_t;

    localparam booth_op_t BOOTH_NOP = 2'd0;
    localparam booth_op_t BOOTH_SUB = 2'd1;
    localparam booth_op_t BOOTH_ADD = 2'd2;

    // Radix-2 recoding of the {Q[0], q_1} bit pair.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return BOOTH_SUB;
            2'b01:   return BOOTH_ADD;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_iter_step.sv
// One radix-2 Booth iteration: WIDTH+1-bit ripple add/sub of M into A,
// followed by an arithmetic right shift of {T, Q, q_1}.
module booth_iter_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_1_nxt
);

    booth_op_t      op;
    logic           sub;
    logic [WIDTH:0] opnd;
    logic [WIDTH:0] carry;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] t;

    assign op   = booth_decode(q[0], q_1);
    assign sub  = (op == BOOTH_SUB);

    // Subtraction as A + ~M + 1; the +1 enters as the ripple carry-in.
    assign opnd     = sub ? ~m : m;
    assign carry[0] = sub;

    // Full-adder chain; the carry out of the top bit is not needed because
    // the extra accumulator bit already absorbs every reachable result.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sum
        assign sum[i] = acc[i] ^ opnd[i] ^ carry[i];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i+1] = (acc[i] & opnd[i]) | (carry[i] & (acc[i] ^ opnd[i]));
    end

    assign t       = (op == BOOTH_NOP) ? acc : sum;
    assign acc_nxt = {t[WIDTH], t[WIDTH:1]};
    assign q_nxt   = {t[0], q[WIDTH-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one shared add/sub step reused over
// WIDTH clock cycles, valid/ready on both operand and product channels.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | applying one Booth step per edge, busy high
// DONE  | product presented with out_valid, held until out_ready
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [WIDTH:0]     m;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;

    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   q_step;
    logic               q_1_step;

    booth_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_step),
        .q_nxt   (q_step),
        .q_1_nxt (q_1_step)
    );

    // Next-state and handshake decode; in_ready is masked while rst is high.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; operands captured only on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                acc <= '0;
                q   <= a;
                q_1 <= 1'b0;
                m   <= {b[WIDTH-1], b};
                cnt <= '0;
            end else if (step) begin
                acc <= acc_step;
                q   <= q_step;
                q_1 <= q_1_step;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The (WIDTH+1)-th accumulator bit is only a guard; it is dropped here.
    assign product = {acc[WIDTH-1:0], q};

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult (WIDTH = 8).
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [15:0] sb[$];
    int          acc_q[$];
    logic        ov_prev = 1'b0;

    booth_seq_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for latency and initiation interval.
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor: latency on each rising out_valid, product on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) chk("unexpected_valid", acc_q.size(), 1);
                else chk("latency", cyc - acc_q.pop_front(), 8);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
                else chk("product", product, sb.pop_front());
            end
            ov_prev <= out_valid;
        end
    end

    task automatic send(input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] exp, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", in_ready, 1);
            acc_cyc = -1;
            return;
        end
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(exp);
        acc_q.push_back(cyc);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, nb, n;
        int p;
        logic [7:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 3*5 with busy-cycle count
        send(8'd3, 8'd5, 16'h000F, t0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) nb++;
        end
        chk("busy_cycles", nb, 8);
        wait_drain();

        // Sign cases and boundaries
        send(8'hF9, 8'h06, 16'hFFD6, t0);
        send(8'h06, 8'hF9, 16'hFFD6, t0);
        send(8'h80, 8'h80, 16'h4000, t0);
        send(8'h80, 8'h7F, 16'hC080, t0);
        send(8'h7F, 8'h7F, 16'h3F01, t0);
        send(8'h00, 8'hFF, 16'h0000, t0);
        wait_drain();

        // Backpressure: hold DONE for 5 cycles while offering a new pair
        out_ready = 1'b0;
        send(8'h05, 8'hFD, 16'hFFF1, t0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a        = 8'h11;
            b        = 8'h22;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_product", product, 16'hFFF1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        wait_drain();

        // Reset in the middle of RUN
        send(8'd3, 8'd5, 16'h000F, t0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", in_ready, 1);
        send(8'd2, 8'd2, 16'h0004, t0);
        wait_drain();

        // Back-to-back with out_ready held high
        send(8'h01, 8'h01, 16'h0001, t0);
        send(8'hFF, 8'hFF, 16'h0001, t1);
        send(8'hFE, 8'h03, 16'hFFFA, t2);
        chk("ii_1", t1 - t0, 10);
        chk("ii_2", t2 - t1, 10);
        wait_drain();

        // Random operands against a signed integer model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            p  = int'($signed(ra)) * int'($signed(rb));
            send(ra, rb, p[15:0], t0);
        end
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
